// File: rtl/vec_issue_ctrl.sv
// Vector instruction issue sequencer: latches one instruction from the scalar core,
// drives decode selects, commits vset* to the CSRs, issues arith/load ops and stalls the core until done.
module vec_issue_ctrl #(
  parameter int XLEN         = 32,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [XLEN-1:0] vec_inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] inst_q,
  output logic [XLEN-1:0] rs1_q,
  output logic [XLEN-1:0] rs2_q,
  input  logic            is_vec,
  output logic            vl_sel,
  output logic            vtype_sel,
  output logic            lumop_sel,
  output logic            rs1rd_de,
  output logic            rs1_sel,
  output logic            csr_we,
  output logic            csr_vl_keep,
  output logic            ex_valid,
  input  logic            ex_ready,
  input  logic            ex_done,
  output logic            busy,
  output logic            resp_valid,
  output logic            resp_err
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int CW = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  state_t        state, state_n;
  logic          err_q, err_n;
  logic [CW-1:0] cnt;

  logic conf, is_vsetvli, is_vsetivli, arith, load;

  always_comb begin
    conf        = (inst_q[6:0] == 7'h57) && (inst_q[14:12] == 3'b111);
    is_vsetvli  = conf && !inst_q[31];
    is_vsetivli = conf && (inst_q[31:30] == 2'b11);
    arith       = (inst_q[6:0] == 7'h57) && (inst_q[14:12] != 3'b111);
    load        = (inst_q[6:0] == 7'h07);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      inst_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      err_q <= err_n;
      if (state == S_IDLE && inst_valid) begin
        inst_q <= vec_inst;
        rs1_q <= rs1_data;
        rs2_q <= rs2_data;
      end
      // counter only runs while waiting, so it is zero on every WAIT entry
      cnt <= (state == S_WAIT) ? cnt + CW'(1) : '0;
    end
  end

  always_comb begin
    state_n     = state;
    err_n       = err_q;
    inst_ready  = 1'b0;
    vl_sel      = 1'b0;
    vtype_sel   = 1'b0;
    lumop_sel   = 1'b0;
    rs1rd_de    = 1'b0;
    rs1_sel     = 1'b0;
    csr_we      = 1'b0;
    csr_vl_keep = 1'b0;
    ex_valid    = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    busy        = (state != S_IDLE);

    if (state != S_IDLE) begin
      vl_sel    = is_vsetivli;
      vtype_sel = is_vsetvli || is_vsetivli;
      lumop_sel = load && (inst_q[27:26] == 2'b00);
      rs1rd_de  = is_vsetivli || (inst_q[19:15] != 5'd0);
      rs1_sel   = is_vsetivli;
    end

    case (state)
      S_IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) state_n = S_DECODE;
      end
      S_DECODE: begin
        if (!is_vec || !(conf || arith || load)) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else if (conf) begin
          csr_we      = 1'b1;
          csr_vl_keep = (inst_q[19:15] == 5'd0) && (inst_q[11:7] == 5'd0) && !is_vsetivli;
          err_n       = 1'b0;
          state_n     = S_DONE;
        end else begin
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ex_valid = 1'b1;
        if (ex_ready) begin
          err_n   = 1'b0;
          state_n = ex_done ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (ex_done) begin
          err_n   = 1'b0;
          state_n = S_DONE;
        end else if ((WAIT_TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // reset abandons the op combinationally: nothing leaks out in the reset cycle
    if (reset) begin
      inst_ready  = 1'b1;
      vl_sel      = 1'b0;
      vtype_sel   = 1'b0;
      lumop_sel   = 1'b0;
      rs1rd_de    = 1'b0;
      rs1_sel     = 1'b0;
      csr_we      = 1'b0;
      csr_vl_keep = 1'b0;
      ex_valid    = 1'b0;
      resp_valid  = 1'b0;
      resp_err    = 1'b0;
      busy        = 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl; expected resp_err values are queued at issue
// and compared by a monitor whenever resp_valid pulses.
module tb_vec_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset, inst_valid, inst_ready, is_vec;
  logic [31:0] vec_inst, rs1_data, rs2_data, inst_q, rs1_q, rs2_q;
  logic        vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel, csr_we, csr_vl_keep;
  logic        ex_valid, ex_ready, ex_done, busy, resp_valid, resp_err;

  int   total = 0;
  int   bad = 0;
  int   resp_cnt = 0;
  logic exp_q[$];
  logic [6:0] dec_sel;
  int   ev_cnt;

  localparam logic [31:0] I_VSETVLI  = {1'b0, 11'h0D0, 5'd6, 3'b111, 5'd5, 7'h57};
  localparam logic [31:0] I_VSETIVLI = {2'b11, 10'h0D0, 5'd7, 3'b111, 5'd1, 7'h57};
  localparam logic [31:0] I_VSETVL   = {2'b10, 5'd0, 5'd2, 5'd0, 3'b111, 5'd0, 7'h57};
  localparam logic [31:0] I_VADD     = {6'd0, 1'b1, 5'd2, 5'd3, 3'b000, 5'd1, 7'h57};
  localparam logic [31:0] I_VLE      = {3'd0, 1'b0, 2'b00, 1'b1, 5'd0, 5'd10, 3'b110, 5'd4, 7'h07};
  localparam logic [31:0] I_VLSE     = {3'd0, 1'b0, 2'b10, 1'b1, 5'd11, 5'd10, 3'b110, 5'd4, 7'h07};
  localparam logic [31:0] I_ADD      = 32'h00B50533;

  vec_issue_ctrl #(.XLEN(32), .WAIT_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .vec_inst(vec_inst), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .inst_q(inst_q), .rs1_q(rs1_q), .rs2_q(rs2_q), .is_vec(is_vec),
    .vl_sel(vl_sel), .vtype_sel(vtype_sel), .lumop_sel(lumop_sel), .rs1rd_de(rs1rd_de),
    .rs1_sel(rs1_sel), .csr_we(csr_we), .csr_vl_keep(csr_vl_keep),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_done(ex_done), .busy(busy),
    .resp_valid(resp_valid), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) chk("resp_spurious", {31'd0, resp_valid}, 32'd0);
      else chk("resp_err", {31'd0, resp_err}, {31'd0, exp_q.pop_front()});
    end
  end

  // Offers one op, captures decode selects, bounds the wait for resp_valid and checks latency.
  task automatic run_op(input string tag, input logic [31:0] inst, input logic [31:0] r1,
                        input logic v, input logic err, input int lat);
    int n;
    vec_inst = inst; rs1_data = r1; rs2_data = ~r1; is_vec = v; inst_valid = 1'b1;
    exp_q.push_back(err);
    step();
    inst_valid = 1'b0;
    dec_sel = {vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel, csr_we, csr_vl_keep};
    chk({tag, "_inst_q"}, inst_q, inst);
    chk({tag, "_rs1_q"}, rs1_q, r1);
    n = 1;
    ev_cnt = 0;
    while (!resp_valid && n < 20) begin
      step();
      if (ex_valid) ev_cnt++;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    step();
  endtask

  initial begin
    int rc;
    reset = 1'b1; inst_valid = 1'b0; is_vec = 1'b1; vec_inst = '0; rs1_data = '0; rs2_data = '0;
    ex_ready = 1'b1; ex_done = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outs", {26'd0, ex_valid, csr_we, resp_valid, vl_sel, vtype_sel, rs1rd_de}, 32'd0);
    chk("rst_inst_q", inst_q, 32'd0);

    run_op("vsetvli", I_VSETVLI, 32'd40, 1'b1, 1'b0, 2);
    chk("vsetvli_sel", {25'd0, dec_sel}, 32'b0101010);
    chk("vsetvli_no_ex", ev_cnt, 0);
    run_op("vsetivli", I_VSETIVLI, 32'd0, 1'b1, 1'b0, 2);
    chk("vsetivli_sel", {25'd0, dec_sel}, 32'b1101110);
    run_op("vsetvl", I_VSETVL, 32'd3, 1'b1, 1'b0, 2);
    chk("vsetvl_sel", {25'd0, dec_sel}, 32'b0000011);
    run_op("vle", I_VLE, 32'h1000, 1'b1, 1'b0, 3);
    chk("vle_sel", {25'd0, dec_sel}, 32'b0011000);
    chk("vle_ex", ev_cnt, 1);
    run_op("vlse", I_VLSE, 32'h2000, 1'b1, 1'b0, 3);
    chk("vlse_sel", {25'd0, dec_sel}, 32'b0001000);
    run_op("vadd_fast", I_VADD, 32'd9, 1'b1, 1'b0, 3);
    run_op("illegal", I_ADD, 32'd5, 1'b0, 1'b1, 2);
    chk("illegal_sel", {25'd0, dec_sel}, 32'b0001000);
    chk("illegal_no_ex", ev_cnt, 0);

    // stalled issue, then completion from WAIT; an offer while busy must be ignored
    ex_ready = 1'b0; ex_done = 1'b0;
    rc = resp_cnt;
    vec_inst = I_VADD; is_vec = 1'b1; inst_valid = 1'b1;
    exp_q.push_back(1'b0);
    step();
    inst_valid = 1'b0;
    chk("stall_dec_ex_valid", {31'd0, ex_valid}, 32'd0);
    ev_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      ex_ready = (k == 3);
      inst_valid = (k == 0);
      if (k == 0) begin
        vec_inst = 32'hDEADBEEF;
        chk("busy_inst_ready", {31'd0, inst_ready}, 32'd0);
      end
      if (ex_valid) ev_cnt++;
      chk("stall_busy", {31'd0, busy}, 32'd1);
    end
    chk("stall_ex_cycles", ev_cnt, 4);
    step();
    ex_ready = 1'b0; ex_done = 1'b1;
    chk("wait_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("busy_inst_q", inst_q, I_VADD);
    step();
    ex_done = 1'b0;
    chk("stall_resp", {31'd0, resp_valid}, 32'd1);
    step();
    chk("stall_resp_once", resp_cnt - rc, 1);
    chk("stall_idle", {31'd0, inst_ready}, 32'd1);

    // WAIT timeout after 8 cycles
    ex_ready = 1'b1; ex_done = 1'b0;
    vec_inst = I_VLE; inst_valid = 1'b1;
    exp_q.push_back(1'b1);
    step();
    inst_valid = 1'b0;
    step();
    for (int w = 0; w < 8; w++) begin
      step();
      chk("to_wait_noresp", {30'd0, busy, resp_valid}, 32'b10);
    end
    step();
    chk("to_resp", {30'd0, resp_valid, resp_err}, 32'b11);
    step();

    // reset while waiting
    rc = resp_cnt;
    vec_inst = I_VADD; inst_valid = 1'b1;
    exp_q.push_back(1'b0);
    step();
    inst_valid = 1'b0;
    step(); step();
    chk("rstw_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw_no_resp", {31'd0, resp_valid}, 32'd0);
    step();
    reset = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("rstw_idle", {30'd0, inst_ready, busy}, 32'b10);
    chk("rstw_inst_q", inst_q, 32'd0);

    // reset while issuing drops ex_valid in the same cycle
    ex_ready = 1'b0;
    vec_inst = I_VLSE; inst_valid = 1'b1;
    exp_q.push_back(1'b0);
    step();
    inst_valid = 1'b0;
    step();
    chk("rsti_ex_valid", {31'd0, ex_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rsti_ex_drop", {31'd0, ex_valid}, 32'd0);
    step();
    reset = 1'b0;
    void'(exp_q.pop_back());
    ex_done = 1'b1;
    step(); step();
    chk("rsti_no_resp", resp_cnt - rc, 0);
    chk("rsti_idle", {31'd0, busy}, 32'd0);

    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
